// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 frame receiver with glitch filter, timeout and FWFT receive queue
// Optional feature macro: PS2_RX_PARITY_CHECK_EN (odd-parity frames are checked and rejected on mismatch)
module ps2_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic                          iPS2Clock,
  input  logic                          iPS2Data,
  output logic [DATA_BITS-1:0]          o8b,
  output logic                          oValid,
  input  logic                          iReady,
  output logic [$clog2(FIFO_DEPTH):0]   oCount,
  output logic                          oFrameError,
  output logic                          oParityError,
  output logic                          oOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]           clk_sync;
  logic [1:0]           dat_sync;
  logic                 filt_clk;
  logic                 filt_d;
  logic [FW-1:0]        filt_cnt;
  logic                 strobe;
  logic                 bit_in;

  state_t               state, state_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [TW-1:0]        to_cnt, to_cnt_n;
  logic                 push_req;
  logic                 frame_err;
  logic                 timeout;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic                 par_bit, par_bit_n;
  logic                 parity_err;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 pop;
  logic                 do_push;

  // Two-flop synchronisers for both pins; idle-high so reset does not fake an edge
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], iPS2Clock};
      dat_sync <= {dat_sync[0], iPS2Data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      filt_clk <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign strobe = filt_d & ~filt_clk;
  assign bit_in = dat_sync[1];

  // Frame state register and registered error pulses
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state       <= S_IDLE;
      bit_idx     <= '0;
      shreg       <= '0;
      to_cnt      <= '0;
      oFrameError <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_bit      <= 1'b0;
      oParityError <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      to_cnt      <= to_cnt_n;
      oFrameError <= frame_err;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_bit      <= par_bit_n;
      oParityError <= parity_err;
`endif
    end
  end

`ifndef PS2_RX_PARITY_CHECK_EN
  assign oParityError = 1'b0;
`endif

  // Frame decode: next state, bit capture, timeout and push/error requests
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push_req  = 1'b0;
    frame_err = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    par_bit_n  = par_bit;
    parity_err = 1'b0;
`endif
    if (state == S_IDLE || strobe) to_cnt_n = '0;
    else                           to_cnt_n = to_cnt + TW'(1);
    timeout = (state != S_IDLE) && !strobe && (to_cnt == TW'(TIMEOUT_CYC - 1));

    if (timeout) begin
      state_n   = S_IDLE;
      frame_err = 1'b1;
      to_cnt_n  = '0;
    end else if (strobe) begin
      case (state)
        S_IDLE: begin
          if (!bit_in) begin
            state_n   = S_DATA;
            bit_idx_n = '0;
          end else begin
            frame_err = 1'b1;
          end
        end
        S_DATA: begin
          shreg_n[bit_idx] = bit_in;
          if (bit_idx == IW'(DATA_BITS - 1)) state_n = S_PARITY;
          else                               bit_idx_n = bit_idx + IW'(1);
        end
        S_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
          par_bit_n = bit_in;
`endif
          state_n = S_STOP;
        end
        S_STOP: begin
          state_n = S_IDLE;
          if (!bit_in) begin
            frame_err = 1'b1;
          end else begin
`ifdef PS2_RX_PARITY_CHECK_EN
            if (^{shreg, par_bit}) push_req = 1'b1;
            else                   parity_err = 1'b1;
`else
            push_req = 1'b1;
`endif
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = oValid & iReady;
  assign do_push = push_req & (~full | pop);

  // Queue storage; contents are meaningless while count is zero, so no reset
  always_ff @(posedge iClock) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // Queue pointers, occupancy and overflow pulse
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      oOverflow <= 1'b0;
    end else begin
      oOverflow <= push_req & full & ~pop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (!do_push && pop) count <= count - CW'(1);
    end
  end

  assign oValid = (count != '0);
  assign oCount = count;
  assign o8b    = oValid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int FL    = 4;
  localparam int TO    = 300;
  localparam int HALF  = 10;
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int EV_FRAME = 1;
  localparam int EV_PAR   = 2;
  localparam int EV_OVF   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2c = 1'b1;
  logic          ps2d = 1'b1;
  logic          rdy = 1'b0;
  logic [DB-1:0] o8b;
  logic          ovalid;
  logic [2:0]    ocount;
  logic          ferr, perr, ovf;

  int checks = 0;
  int errors = 0;
  logic [DB-1:0] exp_q[$];
  int            ev_q[$];

  ps2_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .iClock(clk), .iReset(rst), .iPS2Clock(ps2c), .iPS2Data(ps2d),
    .o8b(o8b), .oValid(ovalid), .iReady(rdy), .oCount(ocount),
    .oFrameError(ferr), .oParityError(perr), .oOverflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ev_seen(input int code);
    int front;
    front = (ev_q.size() > 0) ? ev_q[0] : 0;
    checks++;
    if (front != code) begin
      errors++;
      $display("FAIL pulse_kind: got %0d expected %0d", code, front);
    end else begin
      void'(ev_q.pop_front());
    end
  endtask

  // Monitor: sample 1ns before each rising edge and score pops and pulses
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (ovalid && rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %0h expected none", o8b);
          end else begin
            chk("pop_data", o8b, exp_q.pop_front());
          end
        end
        if (ferr) ev_seen(EV_FRAME);
        if (perr) ev_seen(EV_PAR);
        if (ovf)  ev_seen(EV_OVF);
      end
    end
  end

  task automatic ps2_bit(input logic b, input bit pop_at_strobe);
    @(negedge clk);
    ps2d = b;
    repeat (HALF - 1) @(negedge clk);
    ps2c = 1'b0;
    if (pop_at_strobe) begin
      repeat (2 + FL) @(posedge clk);
      @(negedge clk);
      rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rdy = 1'b0;
      repeat (HALF - 7) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2c = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input logic [DB-1:0] d, input int kind, input bit cpop);
    logic par;
    par = ~^d;
    if (kind == 1) par = ~par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < DB; i++) ps2_bit(d[i], 1'b0);
    ps2_bit(par, 1'b0);
    if (kind == 2)                              ev_q.push_back(EV_FRAME);
    else if (kind == 1 && PAR_EN)               ev_q.push_back(EV_PAR);
    else if (exp_q.size() >= DEPTH && !cpop)    ev_q.push_back(EV_OVF);
    else                                        exp_q.push_back(d);
    ps2_bit((kind == 2) ? 1'b0 : 1'b1, cpop);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_count(input string name);
    chk(name, {29'd0, ocount}, exp_q.size());
    chk({name, "_valid"}, {31'd0, ovalid}, (exp_q.size() != 0) ? 1 : 0);
  endtask

  task automatic drain();
    rdy = 1'b1;
    repeat (12) @(negedge clk);
    rdy = 1'b0;
    check_count("drained");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, ovalid}, 0);
    chk("rst_count", {29'd0, ocount}, 0);
    chk("rst_data", {24'd0, o8b}, 0);
    chk("rst_pulses", {29'd0, ferr, perr, ovf}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame 0x8B
    send_frame(8'h8B, 0, 1'b0);
    chk("first_head", {24'd0, o8b}, 32'h8B);
    check_count("first_count");

    // 0x0F then 0x61 with bad parity
    send_frame(8'h0F, 0, 1'b0);
    send_frame(8'h61, 1, 1'b0);
    check_count("parity_count");
    drain();

    // Bad stop bit, then bad start bit
    send_frame(8'h3C, 2, 1'b0);
    ev_q.push_back(EV_FRAME);
    ps2_bit(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check_count("frame_err_count");
    chk("frame_err_pulses", ev_q.size(), 0);

    // Fill, overflow, then simultaneous push and pop while full
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 0, 1'b0);
    check_count("full_count");
    chk("full_head", {24'd0, o8b}, {24'd0, exp_q[0]});
    send_frame(8'hC3, 0, 1'b1);
    check_count("full_pushpop_count");
    drain();

    // Timeout after four data bits, then recovery
    ev_q.push_back(EV_FRAME);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    repeat (TO + 30) @(negedge clk);
    chk("timeout_pulse", ev_q.size(), 0);
    send_frame(8'h0F, 0, 1'b0);
    chk("after_timeout_head", {24'd0, o8b}, 32'h0F);
    check_count("after_timeout_count");
    drain();

    // Asynchronous reset mid-frame with two queued
    send_frame(8'h12, 0, 1'b0);
    send_frame(8'h34, 0, 1'b0);
    check_count("pre_reset_count");
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, ovalid}, 0);
    chk("async_rst_count", {29'd0, ocount}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'hA5, 0, 1'b0);
    chk("post_reset_head", {24'd0, o8b}, 32'hA5);
    check_count("post_reset_count");
    drain();

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      int r;
      int kind;
      @(negedge clk);
      rdy = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      send_frame(8'($urandom), kind, 1'b0);
      check_count("rand_count");
    end
    rdy = 1'b1;
    repeat (20) @(negedge clk);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_events_empty", ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 receive front end that supersedes the keyboard-clocked serial-to-parallel converter. The PS/2 clock and data lines are oversampled on the single system clock. Each frame (start, DATA_BITS data bits LSB first, odd parity, stop) is decoded and validated, then queued in a first-word-fall-through FIFO with a valid/ready pop handshake. It sits between the keyboard pins and the scan-code decoder and display logic.

## Interface
- DATA_BITS, 8: data bits per frame; also the FIFO word width.
- FIFO_DEPTH, 4: queued frames; power of two, ≥2.
- FILTER_LEN, 4: consecutive equal samples required before filtered PS/2 clock changes.
- TIMEOUT_CYC, 50000: idle system cycles without a PS/2 falling edge that abort a frame in progress.
- iClock  in  1  system clock; sole clock of the block.
- iReset  in  1  asynchronous, active-high reset.
- iPS2Clock  in  1  raw PS/2 clock from pin, asynchronous.
- iPS2Data  in  1  raw PS/2 data from pin, asynchronous.
- o8b  out  DATA_BITS  FIFO head word; valid only while oValid=1.
- oValid  out  1  FIFO not empty.
- iReady  in  1  consumer pops head when oValid&iReady.
- oCount  out  $clog2(FIFO_DEPTH)+1  frames currently queued.
- oFrameError  out  1  1-cycle pulse: bad start/stop bit or timeout.
- oParityError  out  1  1-cycle pulse: parity mismatch.
- oOverflow  out  1  1-cycle pulse: valid frame dropped because FIFO full.

## Operation
- Input path: iPS2Clock and iPS2Data each pass a 2-FF synchroniser. The filtered clock toggles only after FILTER_LEN identical synchronised samples; filtered clock resets to 1. A 1→0 transition of the filtered clock produces a one-cycle strobe, and synchronised data is sampled on that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe, data=0 → DATA with bit index 0; data=1 → oFrameError, stay IDLE.
  - DATA: on strobe, shift bit into position index (LSB first); after bit DATA_BITS-1 → PARITY.
  - PARITY: on strobe, store parity bit → STOP.
  - STOP: on strobe, data=0 → oFrameError. Data=1 with parity OK → push. Either way → IDLE.
- Parity is odd: XOR of data and parity bits must be 1.
- Timeout: in any state except IDLE, a counter of cycles since the last strobe reaching TIMEOUT_CYC forces IDLE and pulses oFrameError; the partial frame is discarded. The counter clears on every strobe and in IDLE.
- FIFO: circular buffer with read/write pointers and count.
  - Push when full: frame dropped, oOverflow pulses, contents unchanged.
  - Push and pop in the same cycle: both occur, count unchanged, including when full.
  - Pop when empty: ignored.
- Only one error pulse per frame; frame error takes priority over parity error.

## Timing
- Reset: all outputs 0, FSM IDLE, FIFO empty, filtered clock 1, pointers 0. Reset asserted mid-frame discards the frame and FIFO contents immediately, without waiting for a clock edge.
- Strobe latency: 2 sync + FILTER_LEN cycles after the pin falling edge.
- Push: stop-bit strobe at cycle N gives the FIFO write, count increment and oValid=1 at N+1.
- o8b shows the new head combinationally from FIFO storage in the same cycle oValid rises.
- Pop: oValid&iReady at edge N; head advances at N+1.
- Error and overflow pulses assert at N+1 after the offending strobe or timeout, for exactly one cycle.

## Configuration
- PS2_RX_PARITY_CHECK_EN defined: parity is checked. A mismatch pulses oParityError at N+1 and the frame is not pushed.
- Not defined: the parity bit is sampled but ignored. Every frame with a correct start and stop bit is pushed, and oParityError is tied to 0.

## Test plan
- Reset, then frame data bits 1,1,0,1,0,0,0,1, parity 1, stop 1 → o8b=0x8B, oValid=1, oCount=1, no error pulses.
- Frames 0x8B, then 0x0F (parity 1), then data 0x61 with parity 1 (bad), with macro defined → queue holds 0x8B, 0x0F; one oParityError pulse. Without macro → 0x61 also queued, oCount=3.
- Frame with stop bit 0, then one with start bit 1 → two oFrameError pulses, oCount=0.
- FIFO_DEPTH=4, iReady=0, send 5 valid frames → oCount=4, one oOverflow pulse, first four values retained in order. Pop with iReady held high while a fifth frame completes in the same cycle → count stays 4.
- Stop toggling PS/2 clock after 4 data bits for TIMEOUT_CYC cycles → oFrameError pulse, FSM IDLE. A following full 0x0F frame is received correctly.
- Assert iReset mid-frame and with 2 frames queued → oValid=0, oCount=0 asynchronously. A full frame after release decodes normally.
